// File: rtl/bootrom_pkg.sv
// Shared constants and scanner state encoding for the boot ROM access controller.
package bootrom_pkg;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 512;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } scan_state_e;

endpackage

// File: rtl/bootrom_scan_fsm.sv
// Integrity scanner: walks the ROM, sums words 0..DEPTH-2 and compares against word DEPTH-1.
module bootrom_scan_fsm #(
   parameter int unsigned ADDR_W    = bootrom_pkg::ADDR_W,
   parameter int unsigned DATA_W    = bootrom_pkg::DATA_W,
   parameter int unsigned DEPTH     = bootrom_pkg::DEPTH,
   parameter bit          AUTO_SCAN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_start,
   input  logic              issue,
   input  logic              rvalid,
   input  logic [DATA_W-1:0] rdata,
   output logic              run,
   output logic [ADDR_W-1:0] scan_addr,
   output logic              scan_busy,
   output logic              scan_done,
   output logic              scan_pass,
   output logic [DATA_W-1:0] scan_sum
);
   import bootrom_pkg::*;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   scan_state_e       state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] sum_q;
   logic              done_q;
   logic              pass_q;
   logic              auto_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         sum_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         auto_q  <= AUTO_SCAN;
      end else begin
         auto_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               // auto_q is only ever set in the first cycle out of reset, i.e. in StIdle
               if (scan_start || auto_q) begin
                  state_q <= StRun;
                  addr_q  <= '0;
                  sum_q   <= '0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end
            end
            StRun: begin
               if (rvalid) sum_q <= sum_q + rdata;
               if (issue) begin
                  addr_q <= addr_q + 1'b1;
                  if (addr_q == LastAddr) state_q <= StDrain;
               end
            end
            StDrain: begin
               // the only return seen here is the checksum word itself
               if (rvalid) begin
                  pass_q  <= (sum_q == rdata);
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign run       = (state_q == StRun);
   assign scan_busy = (state_q == StRun) || (state_q == StDrain);
   assign scan_addr = addr_q;
   assign scan_done = done_q;
   assign scan_pass = pass_q;
   assign scan_sum  = sum_q;

endmodule

// File: rtl/bootrom_ctrl.sv
// Boot ROM port arbiter: CPU fetch has priority, the integrity scanner gets a forced slot
// after STARVE_LIMIT-1 consecutive denials; returning data is steered by a registered owner.
module bootrom_ctrl #(
   parameter int unsigned ADDR_W       = bootrom_pkg::ADDR_W,
   parameter int unsigned DATA_W       = bootrom_pkg::DATA_W,
   parameter int unsigned DEPTH        = bootrom_pkg::DEPTH,
   parameter int unsigned STARVE_LIMIT = 16,
   parameter bit          AUTO_SCAN    = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              scan_start,
   output logic              scan_busy,
   output logic              scan_done,
   output logic              scan_pass,
   output logic [DATA_W-1:0] scan_sum,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   localparam int unsigned CntW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

   logic              scan_run;
   logic              scan_issue;
   logic              force_scan;
   logic [ADDR_W-1:0] scan_addr;
   logic [CntW-1:0]   starve_q;
   logic              cpu_pend_q;
   logic              scan_pend_q;
   logic [DATA_W-1:0] rdata_q;

   assign force_scan = scan_run && (starve_q == CntW'(STARVE_LIMIT - 1));

   // rst gates the grants so nothing is issued while the registers are being cleared
   always_comb begin
      cpu_gnt    = cpu_req & ~force_scan & ~rst;
      scan_issue = scan_run & ~cpu_gnt & ~rst;
      rom_en     = cpu_gnt | scan_issue;
      rom_addr   = '0;
      if (cpu_gnt) begin
         rom_addr = cpu_addr;
      end else if (scan_issue) begin
         rom_addr = scan_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q    <= '0;
         cpu_pend_q  <= 1'b0;
         scan_pend_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         if (scan_issue) begin
            starve_q <= '0;
         end else if (scan_run) begin
            starve_q <= starve_q + 1'b1;
         end
         cpu_pend_q  <= cpu_gnt;
         scan_pend_q <= scan_issue;
         if (cpu_pend_q) rdata_q <= rom_data;
      end
   end

   assign cpu_rvalid = cpu_pend_q;
   assign cpu_rdata  = cpu_pend_q ? rom_data : rdata_q;

   bootrom_scan_fsm #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AUTO_SCAN(AUTO_SCAN)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .scan_start(scan_start),
      .issue     (scan_issue),
      .rvalid    (scan_pend_q),
      .rdata     (rom_data),
      .run       (scan_run),
      .scan_addr (scan_addr),
      .scan_busy (scan_busy),
      .scan_done (scan_done),
      .scan_pass (scan_pass),
      .scan_sum  (scan_sum)
   );

endmodule

// File: tb/tb_bootrom_ctrl.sv
// Self-checking bench for bootrom_ctrl with a behavioural 512x32 synchronous ROM.
module tb_bootrom_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [8:0]  cpu_addr;
   logic        cpu_gnt;
   logic        cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        scan_start;
   logic        scan_busy;
   logic        scan_done;
   logic        scan_pass;
   logic [31:0] scan_sum;
   logic        rom_en;
   logic [8:0]  rom_addr;
   logic [31:0] rom_data = 32'h0;

   logic [31:0] rom_mem [512];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

   bootrom_ctrl #(
      .ADDR_W      (9),
      .DATA_W      (32),
      .DEPTH       (512),
      .STARVE_LIMIT(16),
      .AUTO_SCAN   (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_gnt   (cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .scan_start(scan_start),
      .scan_busy (scan_busy),
      .scan_done (scan_done),
      .scan_pass (scan_pass),
      .scan_sum  (scan_sum),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   typedef struct {
      logic        req;
      logic [8:0]  addr;
      logic        exp_gnt;
      logic        exp_rv;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench just after the edge that starts cycle 0 (first cycle with rst low).
   task automatic do_reset();
      rst        = 1'b1;
      cpu_req    = 1'b1;
      cpu_addr   = 9'd3;
      scan_start = 1'b0;
      @(negedge clk);
      check("rst_gnt", {31'b0, cpu_gnt}, 32'd0);
      check("rst_rom_en", {31'b0, rom_en}, 32'd0);
      step();
      rst     = 1'b0;
      cpu_req = 1'b0;
   endtask

   // Called at the negedge of cycle 'start'; returns the first cycle with scan_done high.
   task automatic wait_done(input int start, output int at);
      int cyc;
      cyc = start;
      at  = -1;
      while (cyc < start + 2000 && at < 0) begin
         step();
         cyc++;
         @(negedge clk);
         if (scan_done) at = cyc;
      end
   endtask

   initial begin
      int          at;
      logic        eg;
      logic        pend_v;
      logic [31:0] pend_d;
      logic [31:0] exp_sum;

      for (int i = 0; i < 511; i++) rom_mem[i] = i;
      rom_mem[511] = 32'h0001FD01;

      // Auto-scan after reset, no CPU traffic
      do_reset();
      @(negedge clk);
      check("c0_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      check("c0_rdata", cpu_rdata, 32'd0);
      check("c0_busy", {31'b0, scan_busy}, 32'd0);
      check("c0_done", {31'b0, scan_done}, 32'd0);
      check("c0_pass", {31'b0, scan_pass}, 32'd0);
      check("c0_sum", scan_sum, 32'd0);
      check("c0_rom_en", {31'b0, rom_en}, 32'd0);
      check("c0_rom_addr", {23'b0, rom_addr}, 32'd0);
      step();
      @(negedge clk);
      check("c1_rom_en", {31'b0, rom_en}, 32'd1);
      check("c1_rom_addr", {23'b0, rom_addr}, 32'd0);
      check("c1_busy", {31'b0, scan_busy}, 32'd1);
      wait_done(1, at);
      check("t1_done_cycle", at, 32'd514);
      check("t1_pass", {31'b0, scan_pass}, 32'd1);
      check("t1_sum", scan_sum, 32'h0001FD01);

      // Restart from DONE with a wrong checksum word
      rom_mem[511] = 32'h0001FD00;
      step();
      scan_start = 1'b1;
      @(negedge clk);
      check("t2_done_at_start", {31'b0, scan_done}, 32'd1);
      step();
      scan_start = 1'b0;
      @(negedge clk);
      check("t2_done_dropped", {31'b0, scan_done}, 32'd0);
      check("t2_sum_cleared", scan_sum, 32'd0);
      check("t2_busy", {31'b0, scan_busy}, 32'd1);
      wait_done(1, at);
      check("t2_done_cycle", at, 32'd514);
      check("t2_pass", {31'b0, scan_pass}, 32'd0);
      check("t2_sum", scan_sum, 32'h0001FD01);

      // CPU reads with scanner idle: back-to-back, hold, and the checksum word
      tbl[0] = '{1'b1, 9'd5,   1'b1, 1'b0, 32'd0};
      tbl[1] = '{1'b1, 9'd6,   1'b1, 1'b1, 32'd5};
      tbl[2] = '{1'b1, 9'd7,   1'b1, 1'b1, 32'd6};
      tbl[3] = '{1'b0, 9'd0,   1'b0, 1'b1, 32'd7};
      tbl[4] = '{1'b0, 9'd0,   1'b0, 1'b0, 32'd7};
      tbl[5] = '{1'b1, 9'd511, 1'b1, 1'b0, 32'd7};
      tbl[6] = '{1'b0, 9'd0,   1'b0, 1'b1, 32'h0001FD00};
      tbl[7] = '{1'b1, 9'd0,   1'b1, 1'b0, 32'h0001FD00};
      tbl[8] = '{1'b0, 9'd0,   1'b0, 1'b1, 32'd0};
      step();
      for (int i = 0; i < 9; i++) begin
         cpu_req  = tbl[i].req;
         cpu_addr = tbl[i].addr;
         @(negedge clk);
         check($sformatf("t3_gnt[%0d]", i), {31'b0, cpu_gnt}, {31'b0, tbl[i].exp_gnt});
         check($sformatf("t3_rom_en[%0d]", i), {31'b0, rom_en}, {31'b0, tbl[i].exp_gnt});
         check($sformatf("t3_rvalid[%0d]", i), {31'b0, cpu_rvalid}, {31'b0, tbl[i].exp_rv});
         check($sformatf("t3_rdata[%0d]", i), cpu_rdata, tbl[i].exp_data);
         step();
      end

      // Continuous random CPU reads during a scan of random ROM contents
      exp_sum = 32'h0;
      for (int i = 0; i < 511; i++) begin
         rom_mem[i] = $urandom;
         exp_sum    = exp_sum + rom_mem[i];
      end
      rom_mem[511] = exp_sum;
      scan_start   = 1'b1;
      cpu_req      = 1'b1;
      cpu_addr     = 9'($urandom_range(0, 511));
      pend_v       = 1'b0;
      pend_d       = 32'h0;
      at           = -1;
      for (int k = 0; k <= 8200; k++) begin
         @(negedge clk);
         // scanner gets every 16th cycle of its run: slots at cycles 16, 32, ..., 16*512
         eg = !(k >= 1 && k <= 16 * 512 && (k % 16) == 0);
         check("t4_gnt", {31'b0, cpu_gnt}, {31'b0, eg});
         check("t4_rvalid", {31'b0, cpu_rvalid}, {31'b0, pend_v});
         if (pend_v) check("t4_rdata", cpu_rdata, pend_d);
         if (k >= 1 && scan_done && at < 0) at = k;
         pend_v = eg;
         pend_d = rom_mem[cpu_addr];
         step();
         scan_start = 1'b0;
         if (eg) cpu_addr = 9'($urandom_range(0, 511));
      end
      cpu_req = 1'b0;
      check("t4_done_cycle", at, 32'd8194);
      check("t4_pass", {31'b0, scan_pass}, 32'd1);
      check("t4_sum", scan_sum, exp_sum);

      // Reset while the scan is at address 200 with a CPU read in flight
      do_reset();
      for (int i = 0; i < 201; i++) step();
      cpu_req  = 1'b1;
      cpu_addr = 9'd33;
      @(negedge clk);
      check("t5_gnt", {31'b0, cpu_gnt}, 32'd1);
      check("t5_rom_addr", {23'b0, rom_addr}, 32'd33);
      check("t5_busy", {31'b0, scan_busy}, 32'd1);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_gnt", {31'b0, cpu_gnt}, 32'd0);
      check("t5_rst_rom_en", {31'b0, rom_en}, 32'd0);
      step();
      rst     = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      check("t5_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      check("t5_rdata", cpu_rdata, 32'd0);
      check("t5_busy_cleared", {31'b0, scan_busy}, 32'd0);
      check("t5_sum_cleared", scan_sum, 32'd0);
      check("t5_done_cleared", {31'b0, scan_done}, 32'd0);
      step();
      @(negedge clk);
      check("t5_restart_en", {31'b0, rom_en}, 32'd1);
      check("t5_restart_addr", {23'b0, rom_addr}, 32'd0);
      check("t5_restart_busy", {31'b0, scan_busy}, 32'd1);

      // Wrap-around checksum
      exp_sum = 32'h0;
      for (int i = 0; i < 511; i++) begin
         rom_mem[i] = 32'hFFFFFFFF;
         exp_sum    = exp_sum + rom_mem[i];
      end
      rom_mem[511] = 32'hFFFFFE01;
      do_reset();
      @(negedge clk);
      wait_done(0, at);
      check("t6_done_cycle", at, 32'd514);
      check("t6_sum", scan_sum, exp_sum);
      check("t6_sum_const", scan_sum, 32'hFFFFFE01);
      check("t6_pass", {31'b0, scan_pass}, {31'b0, exp_sum == rom_mem[511]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
